// File: rtl/alu_serial_flags.sv
// Bit-serial ALU (add/sub/and/or), one bit per cycle LSB first, with registered N/Z/C/V flags.
// Optional sticky overflow flag compiled in when ALU_STICKY_V_EN is defined.
module alu_serial_flags #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       seleccion,
  input  logic             clr_sticky,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             sticky_v
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  op_t              op_q, op_d;
  logic             c_q, c_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             b_bit;
  logic             sum_bit;
  logic             carry_out;
  logic             res_bit;
  logic             arith;

  // Subtraction is A + ~B + 1: B is inverted bit by bit and the carry register starts at 1.
  assign arith     = ~op_q[1];
  assign b_bit     = b_sr_q[0] ^ (op_q == OP_SUB);
  assign sum_bit   = a_sr_q[0] ^ b_bit ^ c_q;
  assign carry_out = (a_sr_q[0] & b_bit) | (c_q & (a_sr_q[0] ^ b_bit));

  always_comb begin
    unique case (op_q)
      OP_AND:  res_bit = a_sr_q[0] & b_sr_q[0];
      OP_OR:   res_bit = a_sr_q[0] | b_sr_q[0];
      default: res_bit = sum_bit;
    endcase
  end

  // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    acc_d    = acc_q;
    op_d     = op_q;
    c_d      = c_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    result_d = result_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          a_sr_d  = a;
          b_sr_d  = b;
          acc_d   = '0;
          op_d    = op_t'(seleccion[1:0]);
          c_d     = (seleccion[1:0] == OP_SUB);
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
        end
      end
      CALC: begin
        if (cnt_q == CW'(WIDTH)) begin
          // All bits are in the accumulator; publish result and flags together with done.
          state_d  = DONE;
          result_d = acc_q;
          neg_d    = acc_q[WIDTH-1];
          zero_d   = (acc_q == '0);
          carry_d  = arith & c_q;
          ovf_d    = arith & ((a_msb_q ^ b_msb_q) == op_q[0]) & (acc_q[WIDTH-1] != a_msb_q);
        end else begin
          acc_d  = {res_bit, acc_q[WIDTH-1:1]};
          a_sr_d = a_sr_q >> 1;
          b_sr_d = b_sr_q >> 1;
          c_d    = carry_out;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      acc_q    <= '0;
      op_q     <= OP_ADD;
      c_q      <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      result_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      c_q      <= c_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == CALC) || (state_q == DONE);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign negative = neg_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

`ifdef ALU_STICKY_V_EN
  logic sticky_q, sticky_d;

  // An overflowing result seen in the DONE cycle wins over a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (state_q == DONE && ovf_q) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_v = sticky_q;
`else
  assign sticky_v = 1'b0;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{seleccion[3:2], clr_sticky};

endmodule

// File: tb/tb_alu_serial_flags.sv
// Self-checking bench for alu_serial_flags (WIDTH=8): directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_alu_serial_flags;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   seleccion;
  logic         clr_sticky;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         negative;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         sticky_v;

  int n_cmp = 0;
  int n_bad = 0;
  logic sticky_m = 1'b0;

  typedef struct packed {
    logic [W-1:0] r;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  alu_serial_flags #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .seleccion  (seleccion),
    .clr_sticky (clr_sticky),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .negative   (negative),
    .zero       (zero),
    .carry      (carry),
    .overflow   (overflow),
    .sticky_v   (sticky_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and two's-complement views of the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] op);
    exp_t e;
    int ux, uy, sx, sy, s;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    e = '0;
    case (op)
      2'b00: begin
        e.r = W'(ux + uy);
        e.c = (ux + uy) > 255;
        s   = sx + sy;
        e.v = (s > 127) || (s < -128);
      end
      2'b01: begin
        e.r = W'(ux - uy);
        e.c = (ux >= uy);
        s   = sx - sy;
        e.v = (s > 127) || (s < -128);
      end
      2'b10:   e.r = x & y;
      default: e.r = x | y;
    endcase
    e.n = e.r[W-1];
    e.z = (e.r == '0);
    return e;
  endfunction

  // Runs one operation: drives start (unless already held), optionally pokes a second start
  // mid-flight, optionally keeps start high afterwards, and checks timing, result, flags and hold.
  task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [3:0] sel,
                       input bit inject, input bit keep_start, input bit preloaded);
    exp_t e;
    int early;
    int busy_gap;
    e = model(aa, bb, sel[1:0]);
    early = 0;
    busy_gap = 0;
    if (!preloaded) begin
      @(negedge clk);
      a = aa;
      b = bb;
      seleccion = sel;
      start = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!keep_start) begin
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      seleccion = 4'($urandom);
    end
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge clk);
      #1;
      if (!busy) busy_gap++;
      if (k <= W && done) early++;
      if (inject && k == 3) begin
        start = 1'b1;
        a = ~aa;
        b = bb ^ 8'h5A;
        seleccion = 4'b0001;
      end
      if (inject && k == 4) start = 1'b0;
    end
    check("done_at_w_plus_1", {31'd0, done}, 32'd1);
    check("no_early_done", early, 0);
    check("busy_held", busy_gap, 0);
    check("result", {24'd0, result}, {24'd0, e.r});
    check("flags_nzcv", {28'd0, negative, zero, carry, overflow}, {28'd0, e.n, e.z, e.c, e.v});
    @(posedge clk);
    #1;
`ifdef ALU_STICKY_V_EN
    sticky_m = sticky_m | e.v;
`endif
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_not_busy", {31'd0, busy}, 32'd0);
    check("result_hold", {24'd0, result}, {24'd0, e.r});
    check("sticky_v", {31'd0, sticky_v}, {31'd0, sticky_m});
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    sticky_m = 1'b0;
    check("sticky_cleared", {31'd0, sticky_v}, {31'd0, sticky_m});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    seleccion = '0;
    clr_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_flags", {28'd0, negative, zero, carry, overflow}, 32'd0);
    check("rst_sticky", {31'd0, sticky_v}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h7F, 8'h01, 4'b0000, 1'b0, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 4'b0001, 1'b0, 1'b0, 1'b0);
    do_op(8'h05, 8'h07, 4'b0001, 1'b0, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 4'b0000, 1'b0, 1'b0, 1'b0);
    do_op(8'hF0, 8'h3C, 4'b0010, 1'b0, 1'b0, 1'b0);
    do_op(8'h12, 8'h34, 4'b1111, 1'b0, 1'b0, 1'b0);

    // Restart attempt mid-operation must be ignored.
    do_op(8'h4C, 8'h21, 4'b0000, 1'b1, 1'b0, 1'b0);

    // Start held through DONE is taken in the following IDLE cycle.
    do_op(8'h33, 8'h44, 4'b0001, 1'b0, 1'b1, 1'b0);
    do_op(8'h33, 8'h44, 4'b0001, 1'b0, 1'b0, 1'b1);

    // Overflowing add, then a clean add, then clear.
    do_op(8'h7F, 8'h01, 4'b0000, 1'b0, 1'b0, 1'b0);
    do_op(8'h01, 8'h01, 4'b0000, 1'b0, 1'b0, 1'b0);
    pulse_clr();

    // Reset in the middle of CALC abandons the operation.
    @(negedge clk);
    a = 8'h11;
    b = 8'h22;
    seleccion = 4'b0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sticky_m = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", {24'd0, result}, 32'd0);
    check("midrst_flags", {28'd0, negative, zero, carry, overflow}, 32'd0);
    check("midrst_sticky", {31'd0, sticky_v}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) @(posedge clk);
    #1;
    check("abandoned_no_done", {31'd0, done | busy}, 32'd0);
    do_op(8'h9A, 8'h66, 4'b0001, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      do_op(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
